muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M extension: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Sits beside the single-cycle ALU in EX. The decoder raises start for OP opcode with funct7=0000001. The core stalls EX while busy=1 and writes back result on done.
- Radix-2 iterative shift-add multiply and restoring divide, one bit per cycle, with sign pre/post correction. Divide-by-zero and signed overflow take a short path.

---
 rtl/muldiv_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: radix-2 shift-add multiply, restoring divide.
// Latency: XLEN+2 cycles start-to-done; divide-by-zero / signed overflow take 2.
// Backpressure: none; start is ignored while busy, kill aborts to IDLE at once.
module muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   CNT_LD = CW'(XLEN-1);

  // State and datapath registers
  logic [1:0]        state_q,   state_d;
  logic [CW-1:0]     count_q,   count_d;
  logic [2:0]        op_q,      op_d;
  logic              sa_q,      sa_d;      // operand A was negative (signed op)
  logic              sb_q,      sb_d;      // operand B was negative (signed op)
  logic              special_q, special_d; // short path taken
  logic              ovf_q,     ovf_d;     // short path cause: 1=overflow, 0=div by zero
  logic [XLEN-1:0]   mcand_q,   mcand_d;   // |multiplicand| or |divisor|
  logic [2*XLEN-1:0] prod_q,    prod_d;    // {hi,lo} product or {rem,quot}
  logic [XLEN-1:0]   result_q,  result_d;

  // Operand decode at start
  logic            is_div;
  logic            signed_a, signed_b;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf;

  // Iteration datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] div_next;

  // Result selection
  logic [2*XLEN-1:0] prod_signed;
  logic [XLEN-1:0]   quot_mag, rem_mag;
  logic [XLEN-1:0]   fix_val;

  // Decode operation class, operand signedness and the short-path conditions
  always_comb begin
    is_div   = funct3[2];
    signed_a = (funct3 == OP_MULH) || (funct3 == OP_MULHSU) ||
               (funct3 == OP_DIV)  || (funct3 == OP_REM);
    signed_b = (funct3 == OP_MULH) || (funct3 == OP_DIV) || (funct3 == OP_REM);
    neg_a    = signed_a & rs1[XLEN-1];
    neg_b    = signed_b & rs2[XLEN-1];
    mag_a    = neg_a ? (~rs1 + ONE_X) : rs1;
    mag_b    = neg_b ? (~rs2 + ONE_X) : rs2;
    div_zero = is_div && (rs2 == '0);
    div_ovf  = ((funct3 == OP_DIV) || (funct3 == OP_REM)) &&
               (rs1 == MIN_X) && (rs2 == '1);
  end

  // One multiply step (add-if-LSB then shift right) and one restoring divide step
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                (prod_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    // Shifted remainder can be XLEN+1 bits wide, so the trial keeps the carry
    div_trial = prod_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
    if (!div_trial[XLEN]) begin
      div_next = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
    end else begin
      div_next = {prod_q[2*XLEN-2:0], 1'b0};
    end
  end

  // Sign correction and result selection used in FIX
  always_comb begin
    // Unsigned ops never latch a sign, so MUL sees the raw low half here
    prod_signed = (sa_q ^ sb_q) ? (~prod_q + {{(2*XLEN-1){1'b0}}, 1'b1}) : prod_q;
    quot_mag    = prod_q[XLEN-1:0];
    rem_mag     = prod_q[2*XLEN-1:XLEN];
    fix_val     = '0;
    if (special_q) begin
      if (ovf_q) begin
        fix_val = op_q[1] ? '0 : MIN_X;
      end else begin
        // Divide by zero: quotient all-ones, remainder is the raw dividend
        fix_val = op_q[1] ? prod_q[XLEN-1:0] : '1;
      end
    end else begin
      case (op_q)
        OP_MUL:                     fix_val = prod_signed[XLEN-1:0];
        OP_MULH, OP_MULHSU,
        OP_MULHU:                   fix_val = prod_signed[2*XLEN-1:XLEN];
        3'b100, 3'b101:             fix_val = (sa_q ^ sb_q) ? (~quot_mag + ONE_X) : quot_mag;
        default:                    fix_val = sa_q ? (~rem_mag + ONE_X) : rem_mag;
      endcase
    end
  end

  // Next-state logic; kill overrides everything else
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    op_d      = op_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    special_d = special_q;
    ovf_d     = ovf_q;
    mcand_d   = mcand_q;
    prod_d    = prod_q;
    result_d  = result_q;
    if (kill) begin
      state_d = S_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d      = funct3;
            sa_d      = neg_a;
            sb_d      = neg_b;
            special_d = div_zero | div_ovf;
            ovf_d     = div_ovf & ~div_zero;
            if (div_zero | div_ovf) begin
              // Keep the raw dividend for REM/REMU by zero
              mcand_d = '0;
              prod_d  = {{XLEN{1'b0}}, rs1};
              count_d = '0;
              state_d = S_FIX;
            end else if (is_div) begin
              mcand_d = mag_b;
              prod_d  = {{XLEN{1'b0}}, mag_a};
              count_d = CNT_LD;
              state_d = S_CALC;
            end else begin
              mcand_d = mag_a;
              prod_d  = {{XLEN{1'b0}}, mag_b};
              count_d = CNT_LD;
              state_d = S_CALC;
            end
          end
        end
        S_CALC: begin
          prod_d = op_q[2] ? div_next : mul_next;
          if (count_q == '0) begin
            state_d = S_FIX;
          end else begin
            count_d = count_q - CW'(1);
          end
        end
        S_FIX: begin
          result_d = fix_val;
          state_d  = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Register update with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      op_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      special_q <= 1'b0;
      ovf_q     <= 1'b0;
      mcand_q   <= '0;
      prod_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      op_q      <= op_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      special_q <= special_d;
      ovf_q     <= ovf_d;
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
      result_q  <= result_d;
    end
  end

  // Outputs come straight from registers
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M vectors with fixed expectations.
// Monitor pops an expected entry on every done and checks value and latency.
// Stimulus also checks busy duration, reset, kill and ignored starts.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          lat;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  logic [31:0] last_res = 32'h0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .kill   (kill),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done with result 0x%08h, expected no done", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_latency"}, 32'(cyc - e.cyc), 32'(e.lat));
        last_res = e.res;
      end
    end
  end

  // Issue one operation; called #1 after a posedge, returns #1 after a posedge
  task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    exp_t e;
    int   n;
    e.res = exp_res; e.cyc = cyc; e.lat = lat; e.name = name;
    exp_q.push_back(e);
    funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy) n++;
      else break;
    end
    check({name, "_busy_cycles"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; funct3 = 3'b0; rs1 = '0; rs2 = '0; kill = 1'b0;
    #3;
    check("reset_busy", {31'b0, busy}, 32'h0);
    check("reset_done", {31'b0, done}, 32'h0);
    check("reset_result", result, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Leave a nonzero result so the mid-operation reset has something to clear
    run_op("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 34);

    // Reset in the middle of CALC: outputs clear immediately, no done
    funct3 = 3'b000; rs1 = 32'd9; rs2 = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    check("midreset_busy", {31'b0, busy}, 32'h0);
    check("midreset_done", {31'b0, done}, 32'h0);
    check("midreset_result", result, 32'h0);
    last_res = 32'h0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("mul_7_m3",       3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34);
    run_op("mulh_min_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
    run_op("mulhu_max_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
    run_op("mulhsu_m1_max",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
    run_op("div_m7_2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34);
    run_op("rem_m7_2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34);
    run_op("divu_100_7b",    3'b101, 32'd100,      32'd7,        32'd14,       34);
    run_op("remu_100_7",     3'b111, 32'd100,      32'd7,        32'd2,        34);
    run_op("div_5_0",        3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
    run_op("rem_5_0",        3'b110, 32'd5,        32'd0,        32'd5,        2);
    run_op("div_ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("rem_ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 2);

    // Kill on cycle 10 of a DIVU, with an extra start while busy that must be dropped
    funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; funct3 = 3'b000; rs1 = 32'd3; rs2 = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'h0);
    check("kill_done", {31'b0, done}, 32'h0);
    check("kill_result", result, last_res);
    run_op("after_kill_divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);

    repeat (5) @(posedge clk);
    #1;
    check("kill_result_hold", result, 32'd14);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "timeout");
  end

endmodule
